shift_seq_ctrl: RTL and testbench

//   Sequencer for the 1-bit-per-cycle shift register datapath. Accepts a parallel word,

---
 rtl/shift_seq_ctrl.sv | 105 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts a word over valid/ready, shifts it one bit per cycle
// for the requested (clamped) count, then holds the result on a valid/ready output.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic             in_dir,
    input  logic             in_fill,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             shift_en
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [AW-1:0] WidthAmt = AW'(WIDTH);
    localparam logic [AW-1:0] OneAmt   = AW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic [AW-1:0]    amt_clamped;

    assign amt_clamped = (in_amt > WidthAmt) ? WidthAmt : in_amt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        fill_d    = fill_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        shift_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort masks ready so a coincident request is refused, not queued
                in_ready = !abort;
                if (in_valid && !abort) begin
                    data_d  = in_data;
                    dir_d   = in_dir;
                    fill_d  = in_fill;
                    cnt_d   = amt_clamped;
                    state_d = (amt_clamped == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    shift_en = 1'b1;
                    data_d   = dir_q ? {fill_q, data_q[WIDTH-1:1]}
                                     : {data_q[WIDTH-2:0], fill_q};
                    cnt_d    = cnt_q - OneAmt;
                    if (cnt_q == OneAmt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                out_valid = !abort;
                if (abort || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign out_data = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus queues expected results, a negedge
// monitor checks result data, shift-step count, latency and hold stability.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [3:0] in_amt = '0;
    logic       in_dir = 1'b0;
    logic       in_fill = 1'b0;
    logic       abort = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;
    logic       shift_en;

    shift_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_fill   (in_fill),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .shift_en  (shift_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         shifts;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard side
    int         acc_cyc = 0;
    int         shifts = 0;
    bit         seen = 0;
    logic [7:0] first_data = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst || abort) begin
            seen = 0;
        end else begin
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                shifts  = 0;
                seen    = 0;
            end
            if (shift_en) shifts++;
            if (out_valid) begin
                if (!seen) begin
                    seen       = 1;
                    first_data = out_data;
                    if (exp_q.size() != 0) check("latency", cyc - acc_cyc, exp_q[0].lat);
                end else begin
                    check("hold_stable", out_data, first_data);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("shift_steps", shifts, e.shifts);
                    end
                    seen = 0;
                end
            end
        end
    end

    // Stimulus side; called at posedge+#1
    task automatic send(input logic [7:0] d, input logic [3:0] amt, input logic dir,
                        input logic fill, input logic [7:0] exp_d);
        exp_t e;
        bit   ok;
        e.data   = exp_d;
        e.shifts = (amt > 8) ? 8 : int'(amt);
        e.lat    = e.shifts + 1;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = amt;
        in_dir   = dir;
        in_fill  = fill;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = 4'd1;
        in_dir   = ~dir;
        in_fill  = ~fill;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        @(posedge clk);
        #1;
        check(name, ok, 1);
    endtask

    initial begin
        bit ok;
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_shift_en", shift_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send(8'h81, 4'd3, 1'b0, 1'b0, 8'h08);
        wait_idle("idle_t1");
        send(8'h81, 4'd2, 1'b1, 1'b1, 8'hE0);
        wait_idle("idle_t2");
        send(8'h5A, 4'd0, 1'b0, 1'b0, 8'h5A);
        wait_idle("idle_t3");
        send(8'h00, 4'd12, 1'b0, 1'b1, 8'hFF);
        wait_idle("idle_t4");
        send(8'hA5, 4'd8, 1'b1, 1'b0, 8'h00);
        wait_idle("idle_exact_width");
        send(8'h80, 4'd1, 1'b0, 1'b1, 8'h01);
        wait_idle("idle_one_step");

        // Backpressure, then a request offered during the output handshake
        out_ready = 1'b0;
        send(8'hF0, 4'd4, 1'b1, 1'b0, 8'h0F);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        check("bp_valid_timeout", ok, 1);
        repeat (5) @(posedge clk);
        #1;
        check("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h81;
        in_amt    = 4'd2;
        in_dir    = 1'b1;
        in_fill   = 1'b1;
        @(negedge clk);
        check("no_accept_in_done", in_ready, 0);
        send(8'h81, 4'd2, 1'b1, 1'b1, 8'hE0);
        wait_idle("idle_after_bp");

        // Reset mid-shift
        send(8'h33, 4'd8, 1'b0, 1'b1, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_data", out_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Abort mid-shift: two steps taken, register keeps 0x01 << 2
        send(8'h01, 4'd6, 1'b0, 1'b0, 8'h40);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_shift_en", shift_en, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_data_kept", out_data, 8'h04);

        // Abort in IDLE refuses a concurrent request
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        check("abort_idle_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_idle_no_accept", busy, 0);

        // Follow-up after abort
        send(8'h3C, 4'd1, 1'b1, 1'b0, 8'h1E);
        wait_idle("idle_followup");

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
